ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single data RAM between the instruction-fetch port and the load/store port of the RV32 core.
- Performs per-cycle grant arbitration with a starvation guard for fetch.
- The RAM has no byte enables, so the block converts sub-word stores (SB/SH) into a two-cycle read-modify-write.
- Sits between the core's fetch/LSU and the RAM macro (one write port, one combinational read port, word-addressed).

Parameters:
- DATA_W, 32, width of the data bus and of a RAM word.
- ADDR_W, 32, width of the byte address.
- STARVE_MAX, 4, maximum consecutive LS grants while a fetch request is pending; range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held with if_addr_i until granted.
- if_addr_i  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch data valid.
- if_rdata_o  out  DATA_W  fetch read data.
- ls_req_i  in  1  LS request; held with all ls_* inputs until granted.
- ls_we_i  in  1  1 = store, 0 = load.
- ls_be_i  in  4  store byte enables; bit k selects byte k.
- ls_addr_i  in  ADDR_W  LS byte address; bits [1:0] ignored.
- ls_wdata_i  in  DATA_W  store data, byte lanes already aligned.
- ls_gnt_o  out  1  LS request accepted this cycle.
- ls_rvalid_o  out  1  load data valid, or store completion acknowledge.
- ls_rdata_o  out  DATA_W  load data; 0 when the response is for a store.
- ram_we_o  out  1  RAM write enable.
- ram_waddr_o  out  ADDR_W  RAM write address.
- ram_wdata_o  out  DATA_W  RAM write data.
- ram_raddr_o  out  ADDR_W  RAM read address.
- ram_rdata_i  in  DATA_W  combinational RAM read data.
- busy_o  out  1  high while in RMW_WR.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, starve counter = 0.
  - All *_gnt_o, *_rvalid_o, ram_we_o and busy_o = 0.
  - All data and address outputs = 0.
  - A read-modify-write in flight is dropped: no RAM write, no acknowledge.
- Address rules:
  - RAM addresses are always {addr[ADDR_W-1:2], 2'b00}.
  - Misaligned low bits are silently ignored.
- Grants:
  - Combinational, issued only in IDLE; at most one grant per cycle.
  - LS has priority.
  - Exception: if if_req_i=1 and the starve counter equals STARVE_MAX, fetch is granted.
- Starve counter:
  - Increments on an LS grant while if_req_i=1.
  - Clears on an IF grant, and on any cycle with if_req_i=0.
  - Saturates at STARVE_MAX.
- Read (fetch or load) granted in cycle N:
  - ram_raddr_o = request address in cycle N.
  - ram_rdata_i is registered at the edge ending cycle N.
  - *_rvalid_o=1 with the data in cycle N+1 for exactly one cycle.
  - Back-to-back reads give one result per cycle.
- Full store (ls_be_i=4'hF) granted in cycle N:
  - ram_we_o=1 in cycle N, with waddr and wdata taken from the request.
  - ls_rvalid_o=1 in cycle N+1, ls_rdata_o=0.
- Partial store (ls_be_i not 4'h0 and not 4'hF) granted in cycle N:
  - Cycle N: ram_raddr_o = request address. The merged word is registered at the end of cycle N: byte k = ls_wdata_i byte k if be[k]=1, else ram_rdata_i byte k.
  - State moves to RMW_WR.
  - Cycle N+1: ram_we_o=1 with the merged word, busy_o=1, no grants, starve counter holds.
  - Cycle N+2: ls_rvalid_o=1, state returns to IDLE.
  - Grants may resume in cycle N+2.
- Store with ls_be_i=4'h0:
  - Granted normally, no RAM write.
  - ls_rvalid_o=1 in cycle N+1.
- Read-after-write visibility:
  - A load granted in the cycle after a full store, or in cycle N+2 after an RMW, returns the new data.
  - This holds because the RAM write lands at the edge.
- Outside a grant cycle and RMW_WR: ram_we_o=0, and ram_raddr_o holds its last value.
- FSM:
  - States: IDLE, RMW_WR.
  - IDLE -> RMW_WR on a partial-store grant.
  - RMW_WR -> IDLE unconditionally after one cycle.

Decomposition:
- Shared defines header:
  - Add arbiter state encodings (ARB_IDLE, ARB_RMW_WR).
  - Add the all-ones and all-zero byte-enable constants.
  - Reuse the existing MEM_BUS, MEM_ADDR_BUS and ZERO_WORD macros.
- One natural sub-module, byte_merge: purely combinational per-lane mux (old word, new word, be) -> merged word.
- Arbitration and FSM stay in ram_arbiter.

Test Plan:
1. Reset mid-RMW: partial store be=4'h1 to 0x10 (RAM word 0x11223344, wdata 0x000000AA). Assert rst low in cycle N+1.
   -> No RAM write, ls_rvalid_o never asserts, all outputs 0, and the word still reads 0x11223344 after reset release.
2. Continuous requests: IF and LS loads requested every cycle, STARVE_MAX=4.
   -> Grant pattern LS,LS,LS,LS,IF repeating, and if_rvalid_o appears every 5th cycle.
3. Partial store: word at 0x20 = 0xDEADBEEF, store be=4'b0110, wdata=0x00ABCD00.
   -> ram_we_o in N+1 with wdata 0xDEABCDEF, ls_rvalid_o in N+2, and a later load returns 0xDEABCDEF.
4. Full store then immediate load: store 0xCAFEF00D to 0x40 in cycle N, load 0x40 in cycle N+1.
   -> ls_rdata_o=0xCAFEF00D in cycle N+2.
5. Misaligned addresses: load from 0x43 and fetch from 0x41.
   -> ram_raddr_o=0x40 in both cases.
6. Zero byte enable: store with be=4'h0.
   -> ram_we_o stays 0, ls_rvalid_o=1 in N+1, and the memory contents are unchanged.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the RAM arbiter: FSM encoding, byte-enable
// constants and the sub-word-store classifier.
package ram_arbiter_pkg;

   localparam int BE_W   = 4;
   localparam int CNT_W  = 4;

   typedef logic [BE_W-1:0] be_t;

   localparam be_t BE_ALL  = 4'hF;
   localparam be_t BE_NONE = 4'h0;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_RMW_WR = 1'b1
   } arb_state_t;

   // A store that touches some but not all lanes needs a read-modify-write.
   function automatic logic be_partial(be_t be);
      return (be != BE_ALL) && (be != BE_NONE);
   endfunction

endpackage

// File: rtl/ram_arbiter_byte_merge.sv
// Per-lane byte merge: each byte comes from the new word when its enable is
// set, otherwise from the old word. Purely combinational.
module byte_merge
   import ram_arbiter_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] old_word,
   input  logic [DATA_W-1:0] new_word,
   input  be_t               be,
   output logic [DATA_W-1:0] merged
);

   always_comb begin
      // NOTE: assigning a full default first keeps every bit driven on every
      // path, so no latch is inferred for the lanes the loop leaves alone.
      merged = old_word;
      for (int k = 0; k < BE_W; k++) begin
         if (be[k]) begin
            merged[k*8 +: 8] = new_word[k*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one word-addressed RAM between instruction fetch and load/store,
// with a fetch starvation guard and read-modify-write for sub-word stores.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,

   input  logic              ls_req_i,
   input  logic              ls_we_i,
   input  be_t               ls_be_i,
   input  logic [ADDR_W-1:0] ls_addr_i,
   input  logic [DATA_W-1:0] ls_wdata_i,
   output logic              ls_gnt_o,
   output logic              ls_rvalid_o,
   output logic [DATA_W-1:0] ls_rdata_o,

   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_waddr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   output logic [ADDR_W-1:0] ram_raddr_o,
   input  logic [DATA_W-1:0] ram_rdata_i,

   output logic              busy_o
);

   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STARVE_MAX);

   arb_state_t        state;
   logic [CNT_W-1:0]  starve_cnt;
   logic [ADDR_W-1:0] raddr_q;
   logic [ADDR_W-1:0] rmw_addr_q;
   logic [DATA_W-1:0] rmw_data_q;

   logic              idle;
   logic              starve_hit;
   logic              ls_full_wr;
   logic              ls_part_wr;
   logic [ADDR_W-1:0] if_addr_al;
   logic [ADDR_W-1:0] ls_addr_al;
   logic [DATA_W-1:0] merged_word;

   assign if_addr_al = if_addr_i & WORD_MASK;
   assign ls_addr_al = ls_addr_i & WORD_MASK;

   // Grants are combinational from the requests, so they are also gated by
   // reset to keep every output quiet while rst is low.
   assign idle       = rst && (state == ARB_IDLE);
   assign starve_hit = (starve_cnt == CNT_MAX);
   assign if_gnt_o   = idle && if_req_i && (!ls_req_i || starve_hit);
   assign ls_gnt_o   = idle && ls_req_i && !(if_req_i && starve_hit);

   assign ls_full_wr = ls_gnt_o && ls_we_i && (ls_be_i == BE_ALL);
   assign ls_part_wr = ls_gnt_o && ls_we_i && be_partial(ls_be_i);

   byte_merge #(.DATA_W(DATA_W)) u_byte_merge (
      .old_word (ram_rdata_i),
      .new_word (ls_wdata_i),
      .be       (ls_be_i),
      .merged   (merged_word)
   );

   always_comb begin
      ram_raddr_o = raddr_q;
      if (if_gnt_o) begin
         ram_raddr_o = if_addr_al;
      end else if (ls_gnt_o) begin
         ram_raddr_o = ls_addr_al;
      end
   end

   always_comb begin
      ram_we_o    = 1'b0;
      ram_waddr_o = '0;
      ram_wdata_o = '0;
      if (ls_full_wr) begin
         ram_we_o    = 1'b1;
         ram_waddr_o = ls_addr_al;
         ram_wdata_o = ls_wdata_i;
      end else if (rst && (state == ARB_RMW_WR)) begin
         ram_we_o    = 1'b1;
         ram_waddr_o = rmw_addr_q;
         ram_wdata_o = rmw_data_q;
      end
   end

   // NOTE: every register here uses non-blocking assignment so all state
   // updates see the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ARB_IDLE;
         starve_cnt  <= '0;
         raddr_q     <= '0;
         rmw_addr_q  <= '0;
         rmw_data_q  <= '0;
         busy_o      <= 1'b0;
         if_rvalid_o <= 1'b0;
         if_rdata_o  <= '0;
         ls_rvalid_o <= 1'b0;
         ls_rdata_o  <= '0;
      end else begin
         if_rvalid_o <= if_gnt_o;
         ls_rvalid_o <= (ls_gnt_o && !ls_part_wr) || (state == ARB_RMW_WR);

         if (if_gnt_o || ls_gnt_o) begin
            raddr_q <= ram_raddr_o;
         end
         if (if_gnt_o) begin
            if_rdata_o <= ram_rdata_i;
         end
         if (ls_gnt_o && !ls_part_wr) begin
            ls_rdata_o <= ls_we_i ? '0 : ram_rdata_i;
         end

         case (state)
            ARB_IDLE: begin
               if (ls_part_wr) begin
                  state      <= ARB_RMW_WR;
                  busy_o     <= 1'b1;
                  rmw_addr_q <= ls_addr_al;
                  rmw_data_q <= merged_word;
               end
               if (!if_req_i || if_gnt_o) begin
                  starve_cnt <= '0;
               end else if (ls_gnt_o && (starve_cnt < CNT_MAX)) begin
                  starve_cnt <= starve_cnt + 1'b1;
               end
            end
            ARB_RMW_WR: begin
               // Write cycle of the RMW; the counter holds and no grant issues.
               state      <= ARB_IDLE;
               busy_o     <= 1'b0;
               ls_rdata_o <= '0;
            end
            default: begin
               state  <= ARB_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural word RAM attached.
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic        if_gnt_o, if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        ls_req_i = 1'b0;
   logic        ls_we_i = 1'b0;
   be_t         ls_be_i = '0;
   logic [31:0] ls_addr_i = '0;
   logic [31:0] ls_wdata_i = '0;
   logic        ls_gnt_o, ls_rvalid_o;
   logic [31:0] ls_rdata_o;
   logic        ram_we_o;
   logic [31:0] ram_waddr_o, ram_wdata_o, ram_raddr_o, ram_rdata_i;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:63];
   int          wr_count = 0;
   logic        bd_we = 1'b0;
   logic [31:0] bd_addr = '0;
   logic [31:0] bd_data = '0;

   always #5 clk = ~clk;

   assign ram_rdata_i = mem[ram_raddr_o[7:2]];

   always @(posedge clk) begin
      if (ram_we_o) begin
         mem[ram_waddr_o[7:2]] <= ram_wdata_o;
         wr_count <= wr_count + 1;
      end
      if (bd_we) mem[bd_addr[7:2]] <= bd_data;
   end

   ram_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
      .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
      .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
      .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o),
      .ram_raddr_o(ram_raddr_o), .ram_rdata_i(ram_rdata_i), .busy_o(busy_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      if_req_i = 1'b0; ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = '0;
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      tick();
      bd_we = 1'b1; bd_addr = addr; bd_data = data;
      tick();
      bd_we = 1'b0;
   endtask

   task automatic do_load(input string name, input logic [31:0] addr,
                          input logic [31:0] exp_raddr, input logic [31:0] exp_data);
      tick();
      ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = '0; ls_addr_i = addr;
      @(negedge clk);
      checks++;
      if ({ls_gnt_o, ram_raddr_o} !== {1'b1, exp_raddr}) begin
         errors++;
         $display("FAIL %s_gnt: gnt=%b raddr=%h, expected gnt=1 raddr=%h", name, ls_gnt_o, ram_raddr_o, exp_raddr);
      end
      tick();
      ls_req_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({ls_rvalid_o, ls_rdata_o} !== {1'b1, exp_data}) begin
         errors++;
         $display("FAIL %s_data: rvalid=%b rdata=%h, expected rvalid=1 rdata=%h", name, ls_rvalid_o, ls_rdata_o, exp_data);
      end
   endtask

   task automatic test_reset();
      if_req_i = 1'b1; ls_req_i = 1'b1; ls_addr_i = 32'h4; if_addr_i = 32'h8;
      #2;
      checks++;
      if ({if_gnt_o, ls_gnt_o, ram_we_o, busy_o, if_rvalid_o, ls_rvalid_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: if_gnt=%b ls_gnt=%b we=%b busy=%b if_rv=%b ls_rv=%b, expected all 0",
                  if_gnt_o, ls_gnt_o, ram_we_o, busy_o, if_rvalid_o, ls_rvalid_o);
      end
      checks++;
      if ({ram_raddr_o, ram_waddr_o, ram_wdata_o, if_rdata_o, ls_rdata_o} !== 160'b0) begin
         errors++;
         $display("FAIL reset_data: raddr=%h waddr=%h wdata=%h if_rdata=%h ls_rdata=%h, expected all 0",
                  ram_raddr_o, ram_waddr_o, ram_wdata_o, if_rdata_o, ls_rdata_o);
      end
      quiet();
      #10;
      rst = 1'b1;
   endtask

   task automatic test_reset_mid_rmw();
      int snap;
      logic seen;
      snap = wr_count;
      tick();
      ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'h1; ls_addr_i = 32'h10; ls_wdata_i = 32'h000000AA;
      @(negedge clk);
      checks++;
      if ({ls_gnt_o, ram_we_o} !== 2'b10) begin
         errors++;
         $display("FAIL rmw_rst_gnt: gnt=%b we=%b, expected gnt=1 we=0", ls_gnt_o, ram_we_o);
      end
      tick();
      quiet();
      rst = 1'b0;
      #1;
      checks++;
      if ({ram_we_o, busy_o, ls_rvalid_o, ram_waddr_o, ram_wdata_o, ram_raddr_o} !== 99'b0) begin
         errors++;
         $display("FAIL rmw_rst_outputs: we=%b busy=%b ls_rv=%b waddr=%h wdata=%h raddr=%h, expected all 0",
                  ram_we_o, busy_o, ls_rvalid_o, ram_waddr_o, ram_wdata_o, ram_raddr_o);
      end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ls_rvalid_o) seen = 1'b1;
         if (i == 2) begin
            #1;
            rst = 1'b1;
         end
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rmw_rst_no_ack: ls_rvalid seen=%b, expected 0", seen);
      end
      checks++;
      if (wr_count !== snap) begin
         errors++;
         $display("FAIL rmw_rst_no_write: writes=%0d, expected %0d", wr_count - snap, 0);
      end
      do_load("rmw_rst_readback", 32'h10, 32'h10, 32'h11223344);
   endtask

   task automatic test_partial_store();
      tick();
      ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'b0110; ls_addr_i = 32'h20; ls_wdata_i = 32'h00ABCD00;
      @(negedge clk);
      checks++;
      if ({ls_gnt_o, ram_we_o, ram_raddr_o} !== {2'b10, 32'h20}) begin
         errors++;
         $display("FAIL rmw_read: gnt=%b we=%b raddr=%h, expected gnt=1 we=0 raddr=00000020", ls_gnt_o, ram_we_o, ram_raddr_o);
      end
      tick();
      ls_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h0;
      @(negedge clk);
      checks++;
      if ({ram_we_o, ram_waddr_o, ram_wdata_o} !== {1'b1, 32'h20, 32'hDEABCDEF}) begin
         errors++;
         $display("FAIL rmw_write: we=%b waddr=%h wdata=%h, expected we=1 waddr=00000020 wdata=deabcdef",
                  ram_we_o, ram_waddr_o, ram_wdata_o);
      end
      checks++;
      if ({busy_o, if_gnt_o, ls_rvalid_o} !== 3'b100) begin
         errors++;
         $display("FAIL rmw_busy: busy=%b if_gnt=%b ls_rv=%b, expected busy=1 if_gnt=0 ls_rv=0", busy_o, if_gnt_o, ls_rvalid_o);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({ls_rvalid_o, ls_rdata_o, busy_o, ram_we_o, if_gnt_o} !== {1'b1, 32'h0, 3'b001}) begin
         errors++;
         $display("FAIL rmw_ack: ls_rv=%b rdata=%h busy=%b we=%b if_gnt=%b, expected 1 00000000 0 0 1",
                  ls_rvalid_o, ls_rdata_o, busy_o, ram_we_o, if_gnt_o);
      end
      tick();
      if_req_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h13579BDF}) begin
         errors++;
         $display("FAIL rmw_fetch_after: if_rv=%b if_rdata=%h, expected 1 13579bdf", if_rvalid_o, if_rdata_o);
      end
      do_load("rmw_readback", 32'h20, 32'h20, 32'hDEABCDEF);
   endtask

   task automatic test_starvation();
      logic [1:0] exp_gnt, exp_rv;
      tick();
      if_req_i = 1'b1; if_addr_i = 32'h0;
      ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h20;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         exp_gnt = (i % 5 == 4) ? 2'b10 : 2'b01;
         exp_rv  = (i == 0) ? 2'b00 : (((i - 1) % 5 == 4) ? 2'b10 : 2'b01);
         checks++;
         if ({if_gnt_o, ls_gnt_o} !== exp_gnt) begin
            errors++;
            $display("FAIL starve_gnt[%0d]: {if,ls}=%b, expected %b", i, {if_gnt_o, ls_gnt_o}, exp_gnt);
         end
         checks++;
         if ({if_rvalid_o, ls_rvalid_o} !== exp_rv) begin
            errors++;
            $display("FAIL starve_rvalid[%0d]: {if,ls}=%b, expected %b", i, {if_rvalid_o, ls_rvalid_o}, exp_rv);
         end
         if (exp_rv == 2'b10) begin
            checks++;
            if (if_rdata_o !== 32'h13579BDF) begin
               errors++;
               $display("FAIL starve_if_data[%0d]: %h, expected 13579bdf", i, if_rdata_o);
            end
         end
      end
      tick();
      quiet();
   endtask

   task automatic test_store_load();
      tick();
      ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'hF; ls_addr_i = 32'h40; ls_wdata_i = 32'hCAFEF00D;
      @(negedge clk);
      checks++;
      if ({ls_gnt_o, ram_we_o, ram_waddr_o, ram_wdata_o} !== {2'b11, 32'h40, 32'hCAFEF00D}) begin
         errors++;
         $display("FAIL full_store: gnt=%b we=%b waddr=%h wdata=%h, expected 1 1 00000040 cafef00d",
                  ls_gnt_o, ram_we_o, ram_waddr_o, ram_wdata_o);
      end
      tick();
      ls_we_i = 1'b0; ls_be_i = '0;
      @(negedge clk);
      checks++;
      if ({ls_rvalid_o, ls_rdata_o, ls_gnt_o, ram_raddr_o} !== {1'b1, 32'h0, 1'b1, 32'h40}) begin
         errors++;
         $display("FAIL store_ack: rv=%b rdata=%h gnt=%b raddr=%h, expected 1 00000000 1 00000040",
                  ls_rvalid_o, ls_rdata_o, ls_gnt_o, ram_raddr_o);
      end
      tick();
      ls_req_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({ls_rvalid_o, ls_rdata_o} !== {1'b1, 32'hCAFEF00D}) begin
         errors++;
         $display("FAIL raw_load: rv=%b rdata=%h, expected 1 cafef00d", ls_rvalid_o, ls_rdata_o);
      end
   endtask

   task automatic test_misaligned();
      do_load("mis_load_23", 32'h23, 32'h20, 32'hDEABCDEF);
      tick();
      if_req_i = 1'b1; if_addr_i = 32'h41;
      @(negedge clk);
      checks++;
      if ({if_gnt_o, ram_raddr_o} !== {1'b1, 32'h40}) begin
         errors++;
         $display("FAIL mis_fetch: gnt=%b raddr=%h, expected 1 00000040", if_gnt_o, ram_raddr_o);
      end
      tick();
      if_req_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'hCAFEF00D}) begin
         errors++;
         $display("FAIL mis_fetch_data: rv=%b rdata=%h, expected 1 cafef00d", if_rvalid_o, if_rdata_o);
      end
      checks++;
      if (ram_raddr_o !== 32'h40) begin
         errors++;
         $display("FAIL raddr_hold: %h, expected 00000040", ram_raddr_o);
      end
      do_load("mis_load_43", 32'h43, 32'h40, 32'hCAFEF00D);
   endtask

   task automatic test_zero_be();
      int snap;
      snap = wr_count;
      tick();
      ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'h0; ls_addr_i = 32'h40; ls_wdata_i = 32'hFFFFFFFF;
      @(negedge clk);
      checks++;
      if ({ls_gnt_o, ram_we_o, busy_o} !== 3'b100) begin
         errors++;
         $display("FAIL zero_be_gnt: gnt=%b we=%b busy=%b, expected 1 0 0", ls_gnt_o, ram_we_o, busy_o);
      end
      tick();
      quiet();
      @(negedge clk);
      checks++;
      if ({ls_rvalid_o, ls_rdata_o, ram_we_o} !== {1'b1, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL zero_be_ack: rv=%b rdata=%h we=%b, expected 1 00000000 0", ls_rvalid_o, ls_rdata_o, ram_we_o);
      end
      do_load("zero_be_readback", 32'h40, 32'h40, 32'hCAFEF00D);
      checks++;
      if (wr_count !== snap) begin
         errors++;
         $display("FAIL zero_be_writes: %0d, expected 0", wr_count - snap);
      end
   endtask

   initial begin
      test_reset();
      preload(32'h00, 32'h13579BDF);
      preload(32'h10, 32'h11223344);
      preload(32'h20, 32'hDEADBEEF);
      preload(32'h40, 32'h00000000);
      test_reset_mid_rmw();
      test_starvation();
      test_partial_store();
      test_store_load();
      test_misaligned();
      test_zero_be();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
